// File: rtl/uart_phase_scheduler.sv
// uart_phase_scheduler: per-frame sequencer that fetches sine samples, scales them
// and launches one byte per UART for each phase, then fires the shoot pulse.
`default_nettype none

module uart_phase_scheduler #(
  parameter int          NUM_OF_MODULES = 9,
  parameter int          NUM_OF_PHASES  = 3,
  parameter logic [15:0] MODULE_OFFSET  = 16'd40,
  parameter logic [15:0] PHASE_OFFSET   = 16'd120,
  parameter int          SHOOT_CYCLES   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [15:0]                 sin_index,
  input  logic [15:0]                 ma_mult,
  output logic [15:0]                 pram_addr,
  input  logic [7:0]                  pram_data,
  output logic [8*NUM_OF_MODULES-1:0] tx_data,
  output logic [NUM_OF_MODULES-1:0]   start_tx,
  input  logic [NUM_OF_MODULES-1:0]   tx_busy,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic                        shoot
);

  localparam int CW = $clog2(NUM_OF_MODULES + 1);
  localparam int PW = (NUM_OF_PHASES > 1) ? $clog2(NUM_OF_PHASES) : 1;
  localparam int SW = (SHOOT_CYCLES > 1) ? $clog2(SHOOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_MOD = CW'(NUM_OF_MODULES);
  localparam logic [PW-1:0] LAST_PH  = PW'(NUM_OF_PHASES - 1);
  localparam logic [SW-1:0] LAST_SH  = SW'(SHOOT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_GUARD  = 3'd3,
    S_DRAIN  = 3'd4,
    S_SHOOT  = 3'd5
  } state_t;

  state_t        state;
  logic [15:0]   ma_q;
  logic [15:0]   phase_base;
  logic [CW-1:0] mod_cnt;
  logic [PW-1:0] ph_cnt;
  logic [SW-1:0] sh_cnt;
  logic [23:0]   product;
  logic [15:0]   next_base;

  always_comb begin
    product   = {16'd0, pram_data} * {8'd0, ma_q};
    next_base = phase_base + PHASE_OFFSET;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      ma_q       <= '0;
      phase_base <= '0;
      mod_cnt    <= '0;
      ph_cnt     <= '0;
      sh_cnt     <= '0;
      pram_addr  <= '0;
      tx_data    <= '0;
      start_tx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      shoot      <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state != S_IDLE && abort) begin
        state    <= S_IDLE;
        start_tx <= '0;
        shoot    <= 1'b0;
        busy     <= 1'b0;
        aborted  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              ma_q       <= ma_mult;
              phase_base <= sin_index;
              pram_addr  <= sin_index;
              ph_cnt     <= '0;
              mod_cnt    <= '0;
              busy       <= 1'b1;
              state      <= S_FETCH;
            end
          end
          S_FETCH: begin
            // Sample for module c arrives while its address is presented; capture and step on.
            if (mod_cnt != LAST_MOD) begin
              tx_data[8*mod_cnt +: 8] <= product[23:16];
              mod_cnt                 <= mod_cnt + 1'b1;
              pram_addr               <= pram_addr + MODULE_OFFSET;
            end else if (tx_busy == '0) begin
              start_tx <= '1;
              state    <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            start_tx <= '0;
            state    <= S_GUARD;
          end
          S_GUARD: state <= S_DRAIN;
          S_DRAIN: begin
            if (tx_busy == '0) begin
              if (ph_cnt != LAST_PH) begin
                ph_cnt     <= ph_cnt + 1'b1;
                mod_cnt    <= '0;
                phase_base <= next_base;
                pram_addr  <= next_base;
                state      <= S_FETCH;
              end else begin
                shoot  <= 1'b1;
                sh_cnt <= '0;
                state  <= S_SHOOT;
              end
            end
          end
          S_SHOOT: begin
            if (sh_cnt == LAST_SH) begin
              shoot <= 1'b0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_phase_scheduler.sv
// tb_uart_phase_scheduler: directed self-checking bench for uart_phase_scheduler.
`default_nettype none
`timescale 1ns/1ps

module tb_uart_phase_scheduler;
  localparam int N = 9;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [15:0]    sin_index = '0;
  logic [15:0]    ma_mult = '0;
  logic [15:0]    pram_addr;
  logic [7:0]     pram_data;
  logic [8*N-1:0] tx_data;
  logic [N-1:0]   start_tx;
  logic [N-1:0]   tx_busy;
  logic           busy, done, aborted, shoot;

  uart_phase_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sin_index(sin_index), .ma_mult(ma_mult),
    .pram_addr(pram_addr), .pram_data(pram_data),
    .tx_data(tx_data), .start_tx(start_tx), .tx_busy(tx_busy),
    .busy(busy), .done(done), .aborted(aborted), .shoot(shoot)
  );

  always #5 clk = ~clk;

  // PRAM model: mem[a] = a[7:0], or a constant 255 when ff_mode is set
  logic ff_mode = 1'b0;
  assign pram_data = ff_mode ? 8'hFF : pram_addr[7:0];

  // UART model: each channel goes busy for blen[i] cycles after its strobe
  logic         ext_busy = 1'b0;
  int           blen [N];
  int           bcnt [N];
  logic [N-1:0] uart_busy;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (start_tx[i]) bcnt[i] <= blen[i];
      else if (bcnt[i] > 0) bcnt[i] <= bcnt[i] - 1;
    end
  end

  always_comb begin
    uart_busy = '0;
    for (int i = 0; i < N; i++) uart_busy[i] = (bcnt[i] != 0);
  end
  assign tx_busy = uart_busy | {N{ext_busy}};

  // Output monitor
  int             cyc = 0;
  int             launches = 0, shoot_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int             bad_strobe = 0, busy_viol = 0, done_after_shoot = 0;
  logic           prev_shoot = 1'b0;
  logic           mon_clr = 1'b0;
  logic [8*N-1:0] ldata [8];
  int             lcyc [8];

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_shoot <= shoot;
    if (mon_clr) begin
      launches <= 0; shoot_cnt <= 0; done_cnt <= 0; abort_cnt <= 0;
      bad_strobe <= 0; busy_viol <= 0; done_after_shoot <= 0;
    end else begin
      if (start_tx != '0) begin
        if (launches < 8) begin
          ldata[launches] <= tx_data;
          lcyc[launches]  <= cyc;
        end
        launches <= launches + 1;
        if (start_tx != '1) bad_strobe <= bad_strobe + 1;
        if (tx_busy != '0) busy_viol <= busy_viol + 1;
      end
      if (shoot) shoot_cnt <= shoot_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (prev_shoot) done_after_shoot <= done_after_shoot + 1;
      end
      if (aborted) abort_cnt <= abort_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Returns in FETCH cycle 0 of phase 0
  task automatic start_frame(input logic [15:0] si, input logic [15:0] ma);
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    sin_index = si;
    ma_mult = ma;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_launches(input string tag, input int want, input int bound);
    int n;
    n = 0;
    while (launches < want && n < bound) begin
      tick();
      n++;
    end
    check(tag, launches, want);
  endtask

  initial begin
    int s;
    for (int i = 0; i < N; i++) blen[i] = 3;

    // Reset state
    repeat (3) tick();
    check("rst_pram_addr", pram_addr, 0);
    check("rst_tx_data_zero", tx_data == '0, 1);
    check("rst_start_tx", start_tx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_shoot", shoot, 0);
    reset = 1'b1;
    tick();

    // Basic frame
    start_frame(16'h0000, 16'h8000);
    check("basic_busy_rise", busy, 1);
    check("basic_addr_c0", pram_addr, 16'h0000);
    tick();
    check("basic_addr_c1", pram_addr, 16'd40);
    finish_frame("basic_frame_end", 400);
    check("basic_launches", launches, 3);
    check("basic_bad_strobe", bad_strobe, 0);
    check("basic_m1_p0", ldata[0][15:8], 20);
    check("basic_m2_p1", ldata[1][23:16], 100);
    check("basic_m8_p2", ldata[2][71:64], 24);
    check("basic_shoot_len", shoot_cnt, 8);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_after_shoot", done_after_shoot, 1);
    check("basic_abort_cnt", abort_cnt, 0);

    // Address wrap and full-scale multiplier
    ff_mode = 1'b1;
    start_frame(16'hFFF0, 16'hFFFF);
    check("wrap_addr_c0", pram_addr, 16'hFFF0);
    tick();
    check("wrap_addr_c1", pram_addr, 16'h0018);
    finish_frame("wrap_frame_end", 400);
    ff_mode = 1'b0;
    check("wrap_m0_p0", ldata[0][7:0], 254);
    check("wrap_m8_p2", ldata[2][71:64], 254);
    check("wrap_done_cnt", done_cnt, 1);

    // Zero multiplier
    start_frame(16'h0000, 16'h0000);
    finish_frame("zero_frame_end", 400);
    check("zero_m2_p1", ldata[1][23:16], 0);

    // Backpressure: launch gated while busy, UART 4 long drain
    blen[4] = 50;
    start_frame(16'h0000, 16'h8000);
    s = cyc;
    ext_busy = 1'b1;
    repeat (20) tick();
    ext_busy = 1'b0;
    finish_frame("bp_frame_end", 1000);
    check("bp_busy_viol", busy_viol, 0);
    check("bp_launches", launches, 3);
    check("bp_first_launch_held", (lcyc[0] - s) >= 20, 1);
    check("bp_second_launch_waits", (lcyc[1] - lcyc[0]) > 50, 1);
    check("bp_m8_p2", ldata[2][71:64], 24);
    check("bp_done_cnt", done_cnt, 1);
    blen[4] = 3;

    // Abort during DRAIN of phase 1
    for (int i = 0; i < N; i++) blen[i] = 10;
    start_frame(16'h0000, 16'h8000);
    wait_launches("abort_reach_launch2", 2, 300);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_pulse", aborted, 1);
    check("abort_busy", busy, 0);
    check("abort_start_tx", start_tx, 0);
    tick();
    check("abort_pulse_one_cycle", aborted, 0);
    repeat (30) tick();
    check("abort_no_shoot", shoot_cnt, 0);
    check("abort_no_done", done_cnt, 0);
    check("abort_cnt", abort_cnt, 1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_start_abort_busy", busy, 0);
    check("idle_start_abort_pulse", aborted, 0);
    repeat (15) tick();
    check("idle_start_abort_no_launch", launches, 2);
    check("idle_start_abort_cnt", abort_cnt, 1);
    for (int i = 0; i < N; i++) blen[i] = 3;

    // Reset mid-FETCH (cycle 4), then a clean frame
    start_frame(16'h0000, 16'h8000);
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("midrst_pram_addr", pram_addr, 0);
    check("midrst_tx_data_zero", tx_data == '0, 1);
    check("midrst_start_tx", start_tx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_flags", {done, aborted, shoot}, 0);
    reset = 1'b1;
    tick();
    start_frame(16'h0000, 16'h8000);
    finish_frame("midrst_frame_end", 400);
    check("midrst_launches", launches, 3);
    check("midrst_m2_p1", ldata[1][23:16], 100);
    check("midrst_m8_p2", ldata[2][71:64], 24);
    check("midrst_done_cnt", done_cnt, 1);

    // Dropped starts during phases 0 and 2
    start_frame(16'h0000, 16'h8000);
    repeat (3) tick();
    sin_index = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_launches("drop_reach_launch2", 2, 300);
    repeat (6) tick();
    ma_mult = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame("drop_frame_end", 400);
    check("drop_launches", launches, 3);
    check("drop_done_cnt", done_cnt, 1);
    check("drop_m2_p1", ldata[1][23:16], 100);
    check("drop_m8_p2", ldata[2][71:64], 24);
    check("drop_shoot_len", shoot_cnt, 8);
    repeat (10) tick();
    check("drop_no_second_frame", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
